// File: rtl/mpu_burst_reader_if.sv
// Command/response bus between the burst reader and the I2C byte master.
// The reader drives the command side; the master drives done/nack/rdata.
interface mpu_burst_reader_if;
   logic       i2c_en;
   logic [6:0] i2c_slave_addr;
   logic       i2c_rw;
   logic [7:0] i2c_reg_addr;
   logic [7:0] i2c_wdata;
   logic       i2c_done;
   logic       i2c_nack;
   logic [7:0] i2c_rdata;

   modport master (
      output i2c_en, i2c_slave_addr, i2c_rw, i2c_reg_addr, i2c_wdata,
      input  i2c_done, i2c_nack, i2c_rdata
   );

   modport slave (
      input  i2c_en, i2c_slave_addr, i2c_rw, i2c_reg_addr, i2c_wdata,
      output i2c_done, i2c_nack, i2c_rdata
   );
endinterface

// File: rtl/mpu_burst_reader.sv
// Reads a burst of big-endian 16-bit words from an I2C sensor (optional wake
// write first) and publishes them atomically, once or periodically.
module mpu_burst_reader #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h69,
   parameter logic [7:0] START_REG     = 8'h41,
   parameter int         NUM_WORDS     = 4,
   parameter bit         WAKE_EN       = 1'b1,
   parameter int         PERIOD        = 1000,
   parameter int         TIMEOUT       = 4095
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     cont,
   mpu_burst_reader_if.master       bus,
   output logic [16*NUM_WORDS-1:0]  sample_data,
   output logic                     sample_valid,
   output logic                     busy,
   output logic                     err
);

   localparam int NBYTES = 2 * NUM_WORDS;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(PERIOD + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NBYTES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE, WAKE_ISSUE, WAKE_WAIT, RD_ISSUE, RD_WAIT, COMMIT, HOLDOFF
   } state_t;

   state_t                    state, state_nx;
   logic [IDX_W-1:0]          idx;
   logic [TMO_W-1:0]          tmo_cnt;
   logic [HOLD_W-1:0]         hold_cnt;
   logic                      woken;
   logic [NBYTES-1:0][7:0]    shadow, merged;
   logic                      idx_clr, idx_inc, woken_set, fail, err_clr;
   logic                      shadow_wr, commit_load;
   logic                      done_ok, txn_fail;

   // Word k = {byte 2k, byte 2k+1}, word 0 in the LSBs.
   function automatic logic [16*NUM_WORDS-1:0] pack_words(input logic [NBYTES-1:0][7:0] b);
      pack_words = '0;
      for (int k = 0; k < NUM_WORDS; k++)
         pack_words[16*k +: 16] = {b[2*k], b[2*k+1]};
   endfunction

   assign done_ok  = bus.i2c_done & ~bus.i2c_nack;
   assign txn_fail = bus.i2c_done ? bus.i2c_nack : (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      idx_clr     = 1'b0;
      idx_inc     = 1'b0;
      woken_set   = 1'b0;
      fail        = 1'b0;
      err_clr     = 1'b0;
      shadow_wr   = 1'b0;
      commit_load = 1'b0;
      case (state)
         IDLE: if (start || cont) begin
            err_clr  = 1'b1;
            idx_clr  = 1'b1;
            state_nx = (WAKE_EN && !woken) ? WAKE_ISSUE : RD_ISSUE;
         end
         WAKE_ISSUE: state_nx = WAKE_WAIT;
         WAKE_WAIT: begin
            if (done_ok) begin
               woken_set = 1'b1;
               state_nx  = RD_ISSUE;
            end else if (txn_fail) begin
               fail     = 1'b1;
               state_nx = IDLE;
            end
         end
         RD_ISSUE: state_nx = RD_WAIT;
         RD_WAIT: begin
            if (done_ok) begin
               shadow_wr = 1'b1;
               if (idx == LAST_IDX) begin
                  commit_load = 1'b1;
                  state_nx    = COMMIT;
               end else begin
                  idx_inc  = 1'b1;
                  state_nx = RD_ISSUE;
               end
            end else if (txn_fail) begin
               fail     = 1'b1;
               state_nx = IDLE;
            end
         end
         COMMIT: state_nx = cont ? HOLDOFF : IDLE;
         HOLDOFF: begin
            if (!cont) begin
               state_nx = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               idx_clr  = 1'b1;
               state_nx = RD_ISSUE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Timers run only in their own states, so every ISSUE restarts the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         woken    <= 1'b0;
         err      <= 1'b0;
         tmo_cnt  <= '0;
         hold_cnt <= '0;
      end else begin
         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + 1'b1;
         if (fail) begin
            err   <= 1'b1;
            woken <= 1'b0;
         end else begin
            if (err_clr)   err   <= 1'b0;
            if (woken_set) woken <= 1'b1;
         end
         tmo_cnt  <= (state == WAKE_WAIT || state == RD_WAIT) ? tmo_cnt + 1'b1 : '0;
         hold_cnt <= (state == HOLDOFF) ? hold_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      merged      = shadow;
      merged[idx] = bus.i2c_rdata;
   end

   always_ff @(posedge clk) begin
      if (shadow_wr) shadow[idx] <= bus.i2c_rdata;
   end

   // The final byte is merged in directly so the new sample is visible in the
   // COMMIT cycle, together with sample_valid.
   always_ff @(posedge clk) begin
      if (rst)              sample_data <= '0;
      else if (commit_load) sample_data <= pack_words(merged);
   end

   always_comb begin
      bus.i2c_en         = (state == WAKE_ISSUE) || (state == RD_ISSUE);
      bus.i2c_slave_addr = SLAVE_ADDRESS;
      bus.i2c_rw         = 1'b0;
      bus.i2c_reg_addr   = 8'h00;
      bus.i2c_wdata      = 8'h00;
      case (state)
         WAKE_ISSUE, WAKE_WAIT: bus.i2c_reg_addr = 8'h6B;
         RD_ISSUE, RD_WAIT: begin
            bus.i2c_rw       = 1'b1;
            bus.i2c_reg_addr = START_REG + 8'(idx);
         end
         default: ;
      endcase
   end

   assign busy         = (state != IDLE);
   assign sample_valid = (state == COMMIT);

endmodule

// File: doc/mpu_burst_reader.md
MPU_BURST_READER -- requirements
Module: mpu_burst_reader

Interface
REQ-001 Parameter SLAVE_ADDRESS, 7'h69, I2C slave address used for every transaction.
REQ-002 Parameter START_REG, 8'h41, first register of the burst.
REQ-003 Parameter NUM_WORDS, 4, number of 16-bit big-endian words per sample (range 1..16).
REQ-004 Parameter WAKE_EN, 1, write 8'h00 to register 8'h6B before the first read after reset or error.
REQ-005 Parameter PERIOD, 1000, cycles from sample_valid to the next auto-restart in continuous mode (range >= 1).
REQ-006 Parameter TIMEOUT, 4095, maximum cycles spent waiting for i2c_done per transaction.
REQ-007 clk  in  1  block clock, shared with the I2C master.
REQ-008 rst  in  1  reset: synchronous, active-high.
REQ-009 start  in  1  one-cycle request for one burst; sampled only in IDLE.
REQ-010 cont  in  1  continuous mode; while high, bursts repeat every PERIOD cycles.
REQ-011 i2c_en  out  1  one-cycle transaction launch pulse to the master.
REQ-012 i2c_slave_addr  out  7  slave address; always SLAVE_ADDRESS.
REQ-013 i2c_rw  out  1  0 = write, 1 = read.
REQ-014 i2c_reg_addr  out  8  target register.
REQ-015 i2c_wdata  out  8  write data, 8'h00 during reads.
REQ-016 i2c_done  in  1  one-cycle completion pulse from the master.
REQ-017 i2c_nack  in  1  qualified by i2c_done; high means the slave did not acknowledge.
REQ-018 i2c_rdata  in  8  read byte; valid in the cycle i2c_done is high.
REQ-019 sample_data  out  16*NUM_WORDS  assembled sample; word 0 in the LSBs; word k = {byte 2k, byte 2k+1}.
REQ-020 sample_valid  out  1  one-cycle pulse when sample_data updates.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 err  out  1  sticky error flag.

Function
REQ-023 States SHALL be IDLE, WAKE_ISSUE, WAKE_WAIT, RD_ISSUE, RD_WAIT, COMMIT, HOLDOFF.
REQ-024 IDLE: on start=1 or cont=1, clear err and byte index; go to WAKE_ISSUE if WAKE_EN=1 and woken=0, otherwise go to RD_ISSUE.
REQ-025 *_ISSUE states: assert i2c_en for exactly one cycle, then enter the matching *_WAIT state; i2c_* command outputs stay stable from ISSUE until i2c_done.
REQ-026 Wake transaction: i2c_rw=0, i2c_reg_addr=8'h6B, i2c_wdata=8'h00; on a clean done, set woken and go to RD_ISSUE.
REQ-027 Read byte idx (0..2*NUM_WORDS-1): i2c_rw=1, i2c_reg_addr=START_REG+idx, truncated to 8 bits (wraps 8'hFF to 8'h00).
REQ-028 RD_WAIT: on a clean done, store i2c_rdata into the shadow buffer at position idx.
  - If idx is not last: increment idx, go to RD_ISSUE.
  - If idx is last: go to COMMIT.
REQ-029 COMMIT (one cycle): copy the whole shadow buffer to sample_data atomically and pulse sample_valid; go to HOLDOFF if cont=1, otherwise go to IDLE.
REQ-030 HOLDOFF: count PERIOD cycles, then clear idx and go to RD_ISSUE (no re-wake); if cont=0 in any HOLDOFF cycle, go to IDLE.
REQ-031 sample_data SHALL never show a partially updated burst; between commits it holds its previous value.
REQ-032 Failure handling: a transaction fails on i2c_done with i2c_nack=1, or when TIMEOUT cycles elapse in a *_WAIT state without i2c_done.
  - On failure: set err, clear woken, go to IDLE.
  - sample_data unchanged, no sample_valid.
REQ-033 Timeout counter SHALL reset on each ISSUE; i2c_done arriving in the same cycle as the timeout expiry counts as completion.
REQ-034 start while busy=1 SHALL be ignored; an err set by failure blocks cont auto-restart only until the next IDLE evaluation (cont=1 retries).
REQ-035 Latency: start to first i2c_en = 1 cycle; last i2c_done to sample_valid = 1 cycle.
REQ-036 i2c_done seen outside a *_WAIT state SHALL be ignored.

Reset
REQ-037 rst=1 SHALL, at the next clk edge, set state=IDLE, i2c_en=0, i2c_rw=0, i2c_reg_addr=0, i2c_wdata=0, sample_data=0, sample_valid=0, err=0, woken=0, and clear all counters.
REQ-038 rst applied mid-transaction SHALL abandon the transaction without a further i2c_en; a later i2c_done SHALL be ignored.

Verification
REQ-039 Default params, single start, slave model returns 8'h10..8'h17: one write to 0x6B, then reads 0x41..0x48; sample_data=64'h1617_1415_1213_1011; one sample_valid; busy low afterwards.
REQ-040 Second start after success: no wake write; 8 reads only.
REQ-041 i2c_nack on byte 3: err=1, sample_data unchanged, busy=0, next start re-issues the wake write.
REQ-042 Slave model withholds done: err rises TIMEOUT+1 cycles after i2c_en; state returns to IDLE.
REQ-043 cont=1, PERIOD=20: sample_valid pulses repeat with exactly 20 holdoff cycles; cont dropped during HOLDOFF -> IDLE with no extra i2c_en.
REQ-044 START_REG=8'hFE, NUM_WORDS=2: read addresses 0xFE, 0xFF, 0x00, 0x01; rst asserted during read 2 -> all outputs at reset values next cycle.
